// File: rtl/neuron_feeder_if.sv
// neuron_feeder_if: config, start/busy/done handshake and neuron-side bus of neuron_feeder
// slave  : the feeder (takes cfg_*, start and nrn_out; drives busy, done, result and nrn_*)
// master : the surrounding logic and the neuron (drives cfg_*, start and nrn_out)
interface neuron_feeder_if #(parameter int N = 10, parameter int AW = 2);
  logic cfg_we;
  logic [1:0] cfg_sel;
  logic [AW-1:0] cfg_addr;
  logic signed [N-1:0] cfg_data;
  logic start;
  logic busy;
  logic done;
  logic signed [N-1:0] result;
  logic nrn_rst;
  logic nrn_inpt_ready;
  logic signed [N-1:0] nrn_w;
  logic signed [N-1:0] nrn_x;
  logic signed [N-1:0] nrn_b;
  logic signed [N-1:0] nrn_out;
  modport slave(input cfg_we, cfg_sel, cfg_addr, cfg_data, start, nrn_out,
                output busy, done, result, nrn_rst, nrn_inpt_ready, nrn_w, nrn_x, nrn_b);
  modport master(output cfg_we, cfg_sel, cfg_addr, cfg_data, start, nrn_out,
                 input busy, done, result, nrn_rst, nrn_inpt_ready, nrn_w, nrn_x, nrn_b);
endinterface

// File: rtl/neuron_feeder.sv
// neuron_feeder: sequences K weight/input pairs and a bias cycle into one MAC neuron, captures its output
// clk, rst : clock, synchronous active-high reset
// bus      : cfg_we/cfg_sel/cfg_addr/cfg_data config writes, start/busy/done handshake, result,
//            nrn_rst/nrn_inpt_ready/nrn_w/nrn_x/nrn_b to the neuron, nrn_out from it
module neuron_feeder #(
  parameter int N = 10,
  parameter int Q = 8,
  parameter int K = 4,
  parameter int AW = 2
) (
  input logic clk,
  input logic rst,
  neuron_feeder_if.slave bus
);
  if (Q >= N || K < 1) begin : g_bad_param
    $error("neuron_feeder: invalid N/Q/K");
  end
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, BIAS, CAPTURE} st_t;
  st_t st_q, st_d;
  logic [AW-1:0] idx_q, idx_d;
  logic signed [N-1:0] w_q [K];
  logic signed [N-1:0] w_d [K];
  logic signed [N-1:0] x_q [K];
  logic signed [N-1:0] x_d [K];
  logic signed [N-1:0] b_q, b_d, nrn_w_q, nrn_w_d, nrn_x_q, nrn_x_d, result_q, result_d;
  logic busy_q, busy_d, done_q, done_d, nrn_rst_q, nrn_rst_d, rdy_q, rdy_d;
  logic cfg_ok, addr_ok;
  always_comb begin
    // config is frozen while a run is in flight
    cfg_ok = bus.cfg_we && !busy_q;
    addr_ok = 32'(bus.cfg_addr) < 32'(K);
    w_d = w_q;
    x_d = x_q;
    b_d = b_q;
    if (cfg_ok && addr_ok && bus.cfg_sel == 2'd0) w_d[bus.cfg_addr] = bus.cfg_data;
    if (cfg_ok && addr_ok && bus.cfg_sel == 2'd1) x_d[bus.cfg_addr] = bus.cfg_data;
    if (cfg_ok && bus.cfg_sel == 2'd2) b_d = bus.cfg_data;
    st_d = st_q;
    idx_d = idx_q;
    case (st_q)
      IDLE: st_d = bus.start ? CLEAR : IDLE;
      CLEAR: begin
        st_d = FEED;
        idx_d = '0;
      end
      FEED: begin
        st_d = idx_q == AW'(K - 1) ? BIAS : FEED;
        idx_d = idx_q + 1'b1;
      end
      BIAS: st_d = CAPTURE;
      default: st_d = IDLE;
    endcase
    // outputs are decoded from the next state so they register in step with it
    busy_d = st_d != IDLE;
    done_d = st_q == CAPTURE;
    nrn_rst_d = st_d == CLEAR;
    rdy_d = st_d == FEED;
    nrn_w_d = rdy_d ? w_q[idx_d] : '0;
    nrn_x_d = rdy_d ? x_q[idx_d] : '0;
    result_d = st_q == CAPTURE ? bus.nrn_out : result_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      idx_q <= '0;
      w_q <= '{default: '0};
      x_q <= '{default: '0};
      b_q <= '0;
      nrn_w_q <= '0;
      nrn_x_q <= '0;
      result_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      nrn_rst_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      w_q <= w_d;
      x_q <= x_d;
      b_q <= b_d;
      nrn_w_q <= nrn_w_d;
      nrn_x_q <= nrn_x_d;
      result_q <= result_d;
      busy_q <= busy_d;
      done_q <= done_d;
      nrn_rst_q <= nrn_rst_d;
      rdy_q <= rdy_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.result = result_q;
  assign bus.nrn_rst = nrn_rst_q;
  assign bus.nrn_inpt_ready = rdy_q;
  assign bus.nrn_w = nrn_w_q;
  assign bus.nrn_x = nrn_x_q;
  assign bus.nrn_b = b_q;
endmodule
